branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Parametrised branch-condition resolver for the pipelined core, placed between execute (ALU flag producer) and fetch (PC select).
- Holds NBANK banks of NZCV flags, each with split NZ and CV write enables.
- Decodes a full 4-bit condition-code set and stalls branches while a flag-setting op is still in flight.
- Forwards same-cycle flag writes and registers a taken/done result, with saturating branch statistics counters.

Parameters:
- NBANK, 2, number of flag banks (context/interrupt banks); must be >= 1.
- BANK_W, 1, width of bank selectors; NBANK <= 2**BANK_W.
- FWD, 1, 1 = same-cycle flag write is forwarded into the evaluation; 0 = stored flags only.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- AluFlags  in  4  {N,Z,C,V}, bits 3..0.
- FlagW  in  2  [1] writes N,Z; [0] writes C,V.
- flag_bank  in  BANK_W  bank targeted by FlagW.
- flags_busy  in  1  a flag-setting op is in flight but has not yet reached FlagW.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_cond  in  4  condition code.
- br_bank  in  BANK_W  bank the branch reads.
- cnt_clr  in  1  synchronous clear of counters.
- pcSrc  out  1  registered: branch taken; meaningful only with br_done.
- br_done  out  1  one-cycle pulse, result valid.
- br_cnt  out  CNT_W  resolved branches.
- taken_cnt  out  CNT_W  taken branches.

Behaviour:
- Reset (async, reset=0): all flag banks = 0, state IDLE, pcSrc=0, br_done=0, counters=0, captured request discarded. A branch waiting at reset never produces br_done.
- Flag write: at the clock edge, bank flag_bank[3:2] <= AluFlags[3:2] if FlagW[1]; [1:0] <= AluFlags[1:0] if FlagW[0]. A flag_bank >= NBANK write is ignored.
- Effective flags for bank b: stored flags of b. With FWD=1, each group whose FlagW bit is set and whose flag_bank==b is replaced by AluFlags. A bank >= NBANK reads as 0000.
- Condition codes (taken when true):
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: ~Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- Handshake: a request transfers on br_valid & br_ready. br_ready = (state==IDLE), a combinational decode of state only; it never depends on br_valid.
- FSM states IDLE, WAIT:
  - IDLE, transfer, flags_busy=0: evaluate br_cond on effective flags of br_bank this cycle. Next edge: br_done=1, pcSrc=result. Stay IDLE; back-to-back branches are accepted every cycle.
  - IDLE, transfer, flags_busy=1: capture cond and bank, go to WAIT.
  - WAIT: br_ready=0. Each cycle flags_busy=0, evaluate captured cond on effective flags (forwarding applies), register the result, go to IDLE. Stays in WAIT while flags_busy=1, with no timeout.
- Latency: 1 cycle from evaluation to br_done. A flag write and an evaluation in the same cycle use the new flags only if FWD=1.
- pcSrc=0 and br_done=0 in every cycle without a completion.
- Counters:
  - On br_done, br_cnt+1; on br_done&pcSrc, taken_cnt+1. Counting happens in the cycle the registered result is visible.
  - Both saturate at all-ones with no wrap.
  - cnt_clr has priority over increment; an increment in the clear cycle is lost.

Decomposition:
- Package cond_pkg: localparams for the 16 condition codes, flag bit indices N=3 Z=2 C=1 V=0, FSM state encoding.
- Sub-module cond_eval (combinational: 4-bit code + 4-bit flags -> taken), instantiated once on the muxed cond/bank.
- Flag banks built from the existing flopenr, two instances per bank (NZ, CV).

Test Plan:
- Reset release, FlagW=11, bank0, AluFlags=0100; next cycle br_cond=0(EQ), bank0, flags_busy=0 -> br_ready=1, next cycle br_done=1, pcSrc=1, br_cnt=1, taken_cnt=1.
- FWD=1: same cycle FlagW=10, AluFlags=1000 to bank1 and branch cond=4(MI) bank1 -> pcSrc=1. With FWD=0 -> pcSrc=0.
- flags_busy=1 for 3 cycles with branch cond=12(GT) -> br_ready=0 for 3 cycles. Busy drops with AluFlags=0001 written -> pcSrc=0, br_done exactly once.
- Bank isolation: write Z=1 to bank1 only, branch EQ on bank0 -> not taken; on bank1 -> taken. Codes 14 -> taken and 15 -> not taken for any flags.
- Counter saturation with CNT_W=2: 5 taken branches -> br_cnt=3, taken_cnt=3. cnt_clr together with a completion -> both 0.
- Assert reset while in WAIT -> no br_done after release, br_ready=1, all flags read 0000.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared encodings for the branch-condition resolver: condition codes,
// NZCV flag bit positions and the resolver FSM state type.
package cond_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] CC_EQ = 4'd0;
   localparam logic [3:0] CC_NE = 4'd1;
   localparam logic [3:0] CC_CS = 4'd2;
   localparam logic [3:0] CC_CC = 4'd3;
   localparam logic [3:0] CC_MI = 4'd4;
   localparam logic [3:0] CC_PL = 4'd5;
   localparam logic [3:0] CC_VS = 4'd6;
   localparam logic [3:0] CC_VC = 4'd7;
   localparam logic [3:0] CC_HI = 4'd8;
   localparam logic [3:0] CC_LS = 4'd9;
   localparam logic [3:0] CC_GE = 4'd10;
   localparam logic [3:0] CC_LT = 4'd11;
   localparam logic [3:0] CC_GT = 4'd12;
   localparam logic [3:0] CC_LE = 4'd13;
   localparam logic [3:0] CC_AL = 4'd14;
   localparam logic [3:0] CC_NV = 4'd15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition-code decode: 4-bit code and NZCV flags
// in, taken out. No state, no handshake.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       taken_o
);

   logic n, z, c, v;

   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];

   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         CC_EQ: taken_o = z;
         CC_NE: taken_o = ~z;
         CC_CS: taken_o = c;
         CC_CC: taken_o = ~c;
         CC_MI: taken_o = n;
         CC_PL: taken_o = ~n;
         CC_VS: taken_o = v;
         CC_VC: taken_o = ~v;
         CC_HI: taken_o = c & ~z;
         CC_LS: taken_o = ~c | z;
         CC_GE: taken_o = (n == v);
         CC_LT: taken_o = (n != v);
         CC_GT: taken_o = ~z & (n == v);
         CC_LE: taken_o = z | (n != v);
         CC_AL: taken_o = 1'b1;
         CC_NV: taken_o = 1'b0;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/flopenr.sv
// Resettable flop with load enable; zero latency beyond the clock edge.
// Asynchronous active-low reset clears q; q holds whenever en is low.
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/branch_cond_unit.sv
// Banked NZCV flags plus branch resolver: result registered one cycle after evaluation.
// br_ready drops only while a captured branch waits for in-flight flags (flags_busy).
module branch_cond_unit
   import cond_pkg::*;
#(
   parameter int NBANK  = 2,
   parameter int BANK_W = 1,
   parameter int FWD    = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        AluFlags,
   input  logic [1:0]        FlagW,
   input  logic [BANK_W-1:0] flag_bank,
   input  logic              flags_busy,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_cond,
   input  logic [BANK_W-1:0] br_bank,
   input  logic              cnt_clr,
   output logic              pcSrc,
   output logic              br_done,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   localparam int NSLOT = 1 << BANK_W;

   // One slot per encodable bank; slots beyond NBANK have no storage and read as zero.
   logic [3:0] eff [NSLOT];

   for (genvar b = 0; b < NSLOT; b++) begin : g_bank
      if (b < NBANK) begin : g_real
         logic       we_nz, we_cv;
         logic [1:0] nz_q, cv_q;

         assign we_nz = FlagW[1] && (flag_bank == BANK_W'(b));
         assign we_cv = FlagW[0] && (flag_bank == BANK_W'(b));

         flopenr #(.WIDTH(2)) u_nz (
            .clk   (clk),
            .reset (reset),
            .en    (we_nz),
            .d     (AluFlags[3:2]),
            .q     (nz_q)
         );

         flopenr #(.WIDTH(2)) u_cv (
            .clk   (clk),
            .reset (reset),
            .en    (we_cv),
            .d     (AluFlags[1:0]),
            .q     (cv_q)
         );

         if (FWD != 0) begin : g_fwd
            assign eff[b] = {we_nz ? AluFlags[3:2] : nz_q,
                             we_cv ? AluFlags[1:0] : cv_q};
         end else begin : g_nofwd
            assign eff[b] = {nz_q, cv_q};
         end
      end else begin : g_none
         assign eff[b] = 4'b0000;
      end
   end

   state_e            state_q, state_d;
   logic [3:0]        cap_cond_q, cap_cond_d;
   logic [BANK_W-1:0] cap_bank_q, cap_bank_d;
   logic              done_q, done_d;
   logic              pc_q, pc_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  tk_cnt_q, tk_cnt_d;

   logic [3:0]        sel_cond;
   logic [BANK_W-1:0] sel_bank;
   logic              taken;

   // A single evaluator serves both the live request and the captured one.
   assign sel_cond = (state_q == ST_WAIT) ? cap_cond_q : br_cond;
   assign sel_bank = (state_q == ST_WAIT) ? cap_bank_q : br_bank;

   cond_eval u_eval (
      .cond_i  (sel_cond),
      .flags_i (eff[sel_bank]),
      .taken_o (taken)
   );

   assign br_ready = (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      cap_cond_d = cap_cond_q;
      cap_bank_d = cap_bank_q;
      done_d     = 1'b0;
      pc_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br_valid) begin
               if (flags_busy) begin
                  state_d    = ST_WAIT;
                  cap_cond_d = br_cond;
                  cap_bank_d = br_bank;
               end else begin
                  done_d = 1'b1;
                  pc_d   = taken;
               end
            end
         end
         ST_WAIT: begin
            if (!flags_busy) begin
               done_d  = 1'b1;
               pc_d    = taken;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters track the registered result, so they lag br_done by one edge.
   always_comb begin
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      if (cnt_clr) begin
         br_cnt_d = '0;
         tk_cnt_d = '0;
      end else begin
         if (done_q && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
         end
         if (done_q && pc_q && (tk_cnt_q != '1)) begin
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cap_cond_q <= '0;
         cap_bank_q <= '0;
         done_q     <= 1'b0;
         pc_q       <= 1'b0;
         br_cnt_q   <= '0;
         tk_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         cap_cond_q <= cap_cond_d;
         cap_bank_q <= cap_bank_d;
         done_q     <= done_d;
         pc_q       <= pc_d;
         br_cnt_q   <= br_cnt_d;
         tk_cnt_q   <= tk_cnt_d;
      end
   end

   assign br_done   = done_q;
   assign pcSrc     = pc_q;
   assign br_cnt    = br_cnt_q;
   assign taken_cnt = tk_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench: three resolvers (forwarding, no forwarding, 2-bit counters)
// share one stimulus stream; expected values are hand-computed.
module tb_branch_cond_unit;
   import cond_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] AluFlags;
   logic [1:0] FlagW;
   logic       flag_bank;
   logic       flags_busy;
   logic       br_valid;
   logic [3:0] br_cond;
   logic       br_bank;
   logic       cnt_clr;

   logic        m_rdy, m_pc, m_done;
   logic [15:0] m_br, m_tk;
   logic        n_rdy, n_pc, n_done;
   logic [15:0] n_br, n_tk;
   logic        s_rdy, s_pc, s_done;
   logic [1:0]  s_br, s_tk;

   int n_chk = 0;
   int n_bad = 0;

   logic [3:0]  pat  [3] = '{4'b1010, 4'b0101, 4'b1001};
   logic [15:0] expv [3] = '{16'h6996, 16'h6A69, 16'h565A};

   always #5 clk = ~clk;

   branch_cond_unit #(.NBANK(2), .BANK_W(1), .FWD(1), .CNT_W(16)) u_main (
      .clk(clk), .reset(reset), .AluFlags(AluFlags), .FlagW(FlagW),
      .flag_bank(flag_bank), .flags_busy(flags_busy), .br_valid(br_valid),
      .br_ready(m_rdy), .br_cond(br_cond), .br_bank(br_bank), .cnt_clr(cnt_clr),
      .pcSrc(m_pc), .br_done(m_done), .br_cnt(m_br), .taken_cnt(m_tk)
   );

   branch_cond_unit #(.NBANK(2), .BANK_W(1), .FWD(0), .CNT_W(16)) u_nofwd (
      .clk(clk), .reset(reset), .AluFlags(AluFlags), .FlagW(FlagW),
      .flag_bank(flag_bank), .flags_busy(flags_busy), .br_valid(br_valid),
      .br_ready(n_rdy), .br_cond(br_cond), .br_bank(br_bank), .cnt_clr(cnt_clr),
      .pcSrc(n_pc), .br_done(n_done), .br_cnt(n_br), .taken_cnt(n_tk)
   );

   branch_cond_unit #(.NBANK(2), .BANK_W(1), .FWD(1), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .AluFlags(AluFlags), .FlagW(FlagW),
      .flag_bank(flag_bank), .flags_busy(flags_busy), .br_valid(br_valid),
      .br_ready(s_rdy), .br_cond(br_cond), .br_bank(br_bank), .cnt_clr(cnt_clr),
      .pcSrc(s_pc), .br_done(s_done), .br_cnt(s_br), .taken_cnt(s_tk)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // The saturating instance forwards, so its pcSrc matches the main one.
   task automatic chk_res(input string tag, input logic done_e, input logic pc_e,
                          input logic pc_nf_e);
      chk({tag, ".m_done"}, 32'(m_done), 32'(done_e));
      chk({tag, ".n_done"}, 32'(n_done), 32'(done_e));
      chk({tag, ".s_done"}, 32'(s_done), 32'(done_e));
      chk({tag, ".m_pc"},   32'(m_pc),   32'(pc_e));
      chk({tag, ".n_pc"},   32'(n_pc),   32'(pc_nf_e));
      chk({tag, ".s_pc"},   32'(s_pc),   32'(pc_e));
   endtask

   task automatic chk_rdy(input string tag, input logic rdy_e);
      chk({tag, ".m_rdy"}, 32'(m_rdy), 32'(rdy_e));
      chk({tag, ".n_rdy"}, 32'(n_rdy), 32'(rdy_e));
      chk({tag, ".s_rdy"}, 32'(s_rdy), 32'(rdy_e));
   endtask

   task automatic chk_cnt(input string tag, input int mb, input int mt,
                          input int nb, input int nt, input int sb, input int st);
      chk({tag, ".m_br"}, 32'(m_br), mb);
      chk({tag, ".m_tk"}, 32'(m_tk), mt);
      chk({tag, ".n_br"}, 32'(n_br), nb);
      chk({tag, ".n_tk"}, 32'(n_tk), nt);
      chk({tag, ".s_br"}, 32'(s_br), sb);
      chk({tag, ".s_tk"}, 32'(s_tk), st);
   endtask

   task automatic quiet();
      FlagW      = 2'b00;
      br_valid   = 1'b0;
      flags_busy = 1'b0;
      cnt_clr    = 1'b0;
   endtask

   task automatic br(input logic [3:0] c, input logic b);
      br_valid = 1'b1;
      br_cond  = c;
      br_bank  = b;
   endtask

   initial begin
      reset     = 1'b0;
      quiet();
      AluFlags  = 4'b0000;
      flag_bank = 1'b0;
      br_cond   = 4'd0;
      br_bank   = 1'b0;
      repeat (2) tick();
      chk_rdy("rst", 1'b1);
      chk_res("rst", 1'b0, 1'b0, 1'b0);
      chk_cnt("rst", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;

      // First branch: Z written to bank0, then EQ.
      FlagW = 2'b11; flag_bank = 1'b0; AluFlags = 4'b0100;
      tick();
      quiet();
      br(CC_EQ, 1'b0);
      chk_rdy("t1", 1'b1);
      tick();
      chk_res("t1", 1'b1, 1'b1, 1'b1);
      br_valid = 1'b0;
      tick();
      chk_res("t1.idle", 1'b0, 1'b0, 1'b0);
      chk_cnt("t1", 1, 1, 1, 1, 1, 1);

      // Same-cycle N write to bank1 with MI on bank1.
      FlagW = 2'b10; flag_bank = 1'b1; AluFlags = 4'b1000;
      br(CC_MI, 1'b1);
      tick();
      quiet();
      chk_res("fwd", 1'b1, 1'b1, 1'b0);
      tick();
      chk_cnt("fwd", 2, 2, 2, 1, 2, 2);

      // GT held back while flags are in flight.
      flags_busy = 1'b1;
      br(CC_GT, 1'b0);
      chk_rdy("busy.acc", 1'b1);
      tick();
      br_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_rdy("busy.wait", 1'b0);
         chk_res("busy.wait", 1'b0, 1'b0, 1'b0);
         tick();
      end
      flags_busy = 1'b0; FlagW = 2'b11; flag_bank = 1'b0; AluFlags = 4'b0001;
      chk_rdy("busy.last", 1'b0);
      tick();
      quiet();
      chk_res("busy.res", 1'b1, 1'b0, 1'b0);
      tick();
      chk_res("busy.once", 1'b0, 1'b0, 1'b0);
      chk_rdy("busy.back", 1'b1);
      chk_cnt("busy", 3, 2, 3, 1, 3, 2);

      // Bank isolation (bank0=0001, bank1 gets Z only) and AL/NV back-to-back.
      FlagW = 2'b11; flag_bank = 1'b1; AluFlags = 4'b0100;
      tick();
      quiet();
      br(CC_EQ, 1'b0); tick(); chk_res("iso.b0", 1'b1, 1'b0, 1'b0);
      br(CC_EQ, 1'b1); tick(); chk_res("iso.b1", 1'b1, 1'b1, 1'b1);
      br(CC_AL, 1'b0); tick(); chk_res("al", 1'b1, 1'b1, 1'b1);
      br(CC_NV, 1'b1); tick(); chk_res("nv", 1'b1, 1'b0, 1'b0);
      br_valid = 1'b0;
      tick();
      chk_res("iso.idle", 1'b0, 1'b0, 1'b0);
      chk_cnt("iso", 7, 4, 7, 3, 3, 3);

      // All sixteen codes against three flag patterns.
      for (int p = 0; p < 3; p++) begin
         FlagW = 2'b11; flag_bank = 1'b0; AluFlags = pat[p];
         tick();
         quiet();
         for (int c = 0; c < 16; c++) begin
            br(4'(c), 1'b0);
            tick();
            chk_res($sformatf("cc%0d.%0d", p, c), 1'b1, expv[p][c], expv[p][c]);
         end
         br_valid = 1'b0;
         tick();
      end

      // Clear, then saturation of the 2-bit counters.
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk_cnt("clr", 0, 0, 0, 0, 0, 0);
      repeat (5) begin
         br(CC_AL, 1'b1);
         tick();
      end
      br_valid = 1'b0;
      tick();
      chk_cnt("sat", 5, 5, 5, 5, 3, 3);

      // Clear coinciding with a visible completion wins.
      br(CC_AL, 1'b0);
      tick();
      br_valid = 1'b0;
      cnt_clr  = 1'b1;
      chk_res("clr.done", 1'b1, 1'b1, 1'b1);
      tick();
      cnt_clr = 1'b0;
      chk_cnt("clrpri", 0, 0, 0, 0, 0, 0);
      tick();
      chk_cnt("clr.hold", 0, 0, 0, 0, 0, 0);

      // Reset while a branch waits in WAIT.
      flags_busy = 1'b1;
      br(CC_AL, 1'b0);
      tick();
      br_valid = 1'b0;
      chk_rdy("rstw.wait", 1'b0);
      #2 reset = 1'b0;
      #1;
      chk_rdy("rstw.in", 1'b1);
      chk_res("rstw.in", 1'b0, 1'b0, 1'b0);
      flags_busy = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_res("rstw.quiet", 1'b0, 1'b0, 1'b0);
         chk_rdy("rstw.quiet", 1'b1);
      end
      chk_cnt("rstw", 0, 0, 0, 0, 0, 0);
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 4; k++) begin
            br(4'(2 * k), 1'(b));
            tick();
            chk_res($sformatf("zero.b%0d.c%0d", b, 2 * k), 1'b1, 1'b0, 1'b0);
         end
         br(CC_GE, 1'(b));
         tick();
         chk_res($sformatf("zero.b%0d.ge", b), 1'b1, 1'b1, 1'b1);
      end
      br_valid = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
